// File: rtl/kanji_ram_fetch.sv
// rtl/kanji_ram_fetch.sv - kanji font byte fetch with CPU wait stretching and one-entry cache
module kanji_ram_fetch #(
    parameter int          ADDR_W   = 27,
    parameter int          TIMEOUT  = 255,
    parameter logic [7:0]  ERR_DATA = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_cs,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              cpu_rd,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [7:0]        mem_data,
    output logic              cpu_wait,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] DRAIN_LAST = 8'd15;

    state_t              state;
    logic [7:0]          cnt;
    logic                ram_cs_d;
    logic                aborted;
    logic                cache_valid;
    logic [ADDR_W-1:0]   cache_addr;
    logic [7:0]          cache_data;

    logic start;
    logic hit;
    logic done;
    logic cpu_live;

    // Decode the start edge, cache hit and transaction completion for this cycle
    always_comb begin
        start    = ram_cs & ~ram_cs_d;
        hit      = cache_valid && (cache_addr == ram_addr) && !flush;
        done     = (state == REQ)  ? (mem_ack && mem_valid) :
                   (state == WAIT) ? mem_valid : 1'b0;
        cpu_live = cpu_rd && !aborted;
    end

    // Fetch FSM; all outputs are registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            ram_cs_d    <= 1'b0;
            aborted     <= 1'b0;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= 8'd0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            cpu_wait    <= 1'b0;
            data_out    <= 8'hFF;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ram_cs_d    <= ram_cs;
            timeout_err <= 1'b0;
            if (flush) begin
                cache_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (hit) begin
                            data_out   <= cache_data;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            mem_addr <= ram_addr;
                            mem_req  <= 1'b1;
                            cpu_wait <= 1'b1;
                            cnt      <= 8'd0;
                            aborted  <= 1'b0;
                            state    <= REQ;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    // CPU gave up: release it now, let the memory side finish quietly
                    if (!cpu_rd) begin
                        aborted  <= 1'b1;
                        cpu_wait <= 1'b0;
                    end
                    if (done) begin
                        // Completion beats a timeout landing on the same cycle
                        mem_req     <= 1'b0;
                        cpu_wait    <= 1'b0;
                        cache_addr  <= mem_addr;
                        cache_data  <= mem_data;
                        cache_valid <= ~flush;
                        if (cpu_live) begin
                            data_out   <= mem_data;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == TO_LAST) begin
                        mem_req     <= 1'b0;
                        cpu_wait    <= 1'b0;
                        timeout_err <= 1'b1;
                        cnt         <= 8'd0;
                        state       <= DRAIN;
                        if (cpu_live) begin
                            data_out   <= ERR_DATA;
                            data_valid <= 1'b1;
                        end
                    end else if (state == REQ && mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                DRAIN: begin
                    // A late reply after abort is swallowed so it cannot feed the next read
                    cnt <= cnt + 8'd1;
                    if (mem_valid || cnt == DRAIN_LAST) begin
                        cnt   <= 8'd0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!cpu_rd) begin
                        data_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/kanji_ram_fetch.md
Name: kanji_ram_fetch

Overview:
- Downstream stage of the kanji font-ROM address generator.
- Consumes its `ram_cs`/`ram_addr` strobe and issues one byte read to the shared SDRAM port via req/ack/valid handshake.
- Stretches the CPU IO read with `cpu_wait` until data returns, then drives the font byte onto the CPU data path.
- One-entry last-address cache lets repeated reads of the same byte skip memory.

Parameters:
- ADDR_W, 27, width of font RAM address.
- TIMEOUT, 255, max cycles spent in REQ+WAIT before abort (8-bit counter, 1..255).
- ERR_DATA, 8'hFF, byte returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ram_cs  in  1  read strobe from kanji address generator; level, may stay high several cycles.
- ram_addr  in  ADDR_W  byte address, valid while ram_cs=1.
- cpu_rd  in  1  CPU IO read in progress (iorq & rd & port decode).
- flush  in  1  invalidate cache (font RAM rewritten/reloaded).
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  memory address, stable while mem_req=1.
- mem_ack  in  1  request accepted (1-cycle pulse).
- mem_valid  in  1  read data valid (1-cycle pulse).
- mem_data  in  8  read data.
- cpu_wait  out  1  CPU wait request.
- data_out  out  8  byte to CPU data mux.
- data_valid  out  1  data_out valid for current read.
- timeout_err  out  1  1-cycle pulse on abort.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, cpu_wait=0, data_out=8'hFF, data_valid=0, timeout_err=0, state=IDLE, cache invalid, cnt=0, ram_cs_d=0.
- Start event: ram_cs & ~ram_cs_d (rising edge, registered ram_cs_d). Accepted only in IDLE; ignored in all other states.
- IDLE:
  - Start with cache hit (cache_valid & cache_addr==ram_addr & ~flush): data_out<=cache_data, data_valid<=1, cpu_wait stays 0, next HOLD. Zero added wait.
  - Start with miss: mem_addr<=ram_addr, mem_req<=1, cpu_wait<=1, cnt<=0, next REQ. cpu_wait is high the cycle after the edge.
- REQ:
  - mem_req held until mem_ack; then mem_req<=0, next WAIT.
  - mem_ack and mem_valid in the same cycle: data is taken; handle as WAIT completion.
- WAIT: on mem_valid, data_out<=mem_data, data_valid<=1, cpu_wait<=0, cache_addr<=mem_addr, cache_data<=mem_data, cache_valid<=1, next HOLD.
- Timeout: cnt increments each cycle in REQ/WAIT. When cnt==TIMEOUT-1 and no completion that cycle:
  - mem_req<=0, data_out<=ERR_DATA, data_valid<=1, cpu_wait<=0, timeout_err pulse, cache untouched, next DRAIN.
  - Completion in the same cycle wins over timeout.
- DRAIN: swallows a late mem_valid (data discarded). Exits to HOLD on mem_valid or after 16 cycles, whichever first. Prevents stale data reaching the next read.
- HOLD: data_out/data_valid held while cpu_rd=1. When cpu_rd=0: data_valid<=0, next IDLE. data_out keeps its last value.
- flush: clears cache_valid in any state. If flush coincides with a WAIT fill, flush wins (valid=0).
- cpu_rd dropping in REQ/WAIT (CPU abort): the memory transaction completes, cache is filled, no CPU data, then IDLE.
- Reset mid-transaction: immediate return to IDLE. mem_ack/mem_valid arriving afterwards are ignored (IDLE does not sample them).
- Wrap: cnt saturates and never wraps. ram_addr is used as given; no masking in this block.
- Latency (miss): cpu_wait = 1 + (cycles to mem_ack) + (cycles to mem_valid). Hit adds 0.

Test Plan:
- Miss: ram_cs rise, ram_addr=27'h00123; ack after 2, valid after 4 with 8'h5A -> mem_addr=27'h00123, cpu_wait high 5 cycles, data_out=5A, data_valid until cpu_rd falls.
- Hit: repeat same address -> mem_req never asserts, data_out=5A next cycle, cpu_wait=0. Then flush and repeat -> full miss.
- Timeout: no ack, TIMEOUT=255 -> cpu_wait falls after 255 cycles, data_out=FF, timeout_err single pulse. Late mem_valid=77 in DRAIN -> ignored, next read not polluted.
- Simultaneous: mem_ack and mem_valid same cycle with data 8'hC3 -> HOLD, data_out=C3. Completion on final timeout cycle -> data accepted, no timeout_err.
- Reset in WAIT, then mem_valid pulse -> outputs stay at reset values, state IDLE, cache invalid.
- ram_cs held high 3 cycles, second edge during HOLD -> exactly one mem_req; edge while busy ignored.
